// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode
//  Description : RISC-V decode stage. Holds the 32-entry register file with
//                write-through reads, the main/ALU control decoder and the
//                immediate extender, and registers everything into ID/EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] instrD,
  input  logic [WORD_WIDTH-1:0] PCD,
  input  logic [WORD_WIDTH-1:0] PCPlus4D,
  input  logic                  FlushE,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [WORD_WIDTH-1:0] ResultW,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic [WORD_WIDTH-1:0] RD1E,
  output logic [WORD_WIDTH-1:0] RD2E,
  output logic [WORD_WIDTH-1:0] ImmExtE,
  output logic [WORD_WIDTH-1:0] PCE,
  output logic [WORD_WIDTH-1:0] PCPlus4E,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  IllegalE
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  localparam logic [2:0] c_IMM_NONE = 3'd0;
  localparam logic [2:0] c_IMM_I    = 3'd1;
  localparam logic [2:0] c_IMM_S    = 3'd2;
  localparam logic [2:0] c_IMM_B    = 3'd3;
  localparam logic [2:0] c_IMM_J    = 3'd4;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [2:0]            alu_ctrl;
    logic                  illegal;
    logic [WORD_WIDTH-1:0] rd1;
    logic [WORD_WIDTH-1:0] rd2;
    logic [WORD_WIDTH-1:0] imm;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_plus4;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
  } id_ex_t;

  logic [WORD_WIDTH-1:0] r_regs [NUM_REGS];
  id_ex_t                r_id_ex;
  id_ex_t                w_id_ex;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic                  w_funct7_5;
  logic                  w_reg_write;
  logic                  w_mem_write;
  logic                  w_alu_src;
  logic [1:0]            w_result_src;
  logic                  w_branch;
  logic                  w_jump;
  logic [2:0]            w_alu_ctrl;
  logic [2:0]            w_imm_src;
  logic                  w_illegal;
  logic [WORD_WIDTH-1:0] w_imm;
  logic [WORD_WIDTH-1:0] w_rd1;
  logic [WORD_WIDTH-1:0] w_rd2;
  logic                  w_wb_en;

  assign w_opcode   = instrD[6:0];
  assign w_funct3   = instrD[14:12];
  assign w_funct7_5 = instrD[30];
  assign Rs1D       = instrD[19:15];
  assign Rs2D       = instrD[24:20];
  assign w_wb_en    = RegWriteW && (RdW != 5'd0);

  // Register file: x0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[RdW] <= ResultW;
    end
  end

  // Asynchronous reads with write-through of the same-cycle writeback.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (Rs1D != 5'd0) begin
      w_rd1 = (w_wb_en && (RdW == Rs1D)) ? ResultW : r_regs[Rs1D];
    end
    if (Rs2D != 5'd0) begin
      w_rd2 = (w_wb_en && (RdW == Rs2D)) ? ResultW : r_regs[Rs2D];
    end
  end

  // Main and ALU control decode; any unsupported encoding yields all-zero
  // controls with the illegal flag raised.
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_ctrl   = c_ALU_ADD;
    w_imm_src    = c_IMM_NONE;
    w_illegal    = 1'b0;
    case (w_opcode)
      c_OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_imm_src    = c_IMM_I;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      c_OP_STORE: begin
        w_imm_src   = c_IMM_S;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_BRANCH: begin
        w_imm_src  = c_IMM_B;
        w_branch   = 1'b1;
        w_alu_ctrl = c_ALU_SUB;
      end
      c_OP_JAL: begin
        w_reg_write  = 1'b1;
        w_imm_src    = c_IMM_J;
        w_result_src = 2'b10;
        w_jump       = 1'b1;
      end
      c_OP_REG, c_OP_IMM: begin
        w_reg_write = 1'b1;
        if (w_opcode == c_OP_IMM) begin
          w_imm_src = c_IMM_I;
          w_alu_src = 1'b1;
        end
        case (w_funct3)
          3'b000:  w_alu_ctrl = (w_opcode == c_OP_REG && w_funct7_5) ? c_ALU_SUB : c_ALU_ADD;
          3'b010:  w_alu_ctrl = c_ALU_SLT;
          3'b100:  w_alu_ctrl = c_ALU_XOR;
          3'b110:  w_alu_ctrl = c_ALU_OR;
          3'b111:  w_alu_ctrl = c_ALU_AND;
          default: w_illegal  = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_result_src = 2'b00;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_alu_ctrl   = c_ALU_ADD;
      w_imm_src    = c_IMM_NONE;
    end
  end

  // Sign-extended immediate for the selected format.
  always_comb begin
    w_imm = '0;
    case (w_imm_src)
      c_IMM_I: w_imm = {{(WORD_WIDTH-12){instrD[31]}}, instrD[31:20]};
      c_IMM_S: w_imm = {{(WORD_WIDTH-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
      c_IMM_B: w_imm = {{(WORD_WIDTH-13){instrD[31]}}, instrD[31], instrD[7],
                        instrD[30:25], instrD[11:8], 1'b0};
      c_IMM_J: w_imm = {{(WORD_WIDTH-21){instrD[31]}}, instrD[31], instrD[19:12],
                        instrD[20], instrD[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Assemble the next ID/EX contents.
  always_comb begin
    w_id_ex            = '0;
    w_id_ex.reg_write  = w_reg_write;
    w_id_ex.mem_write  = w_mem_write;
    w_id_ex.jump       = w_jump;
    w_id_ex.branch     = w_branch;
    w_id_ex.alu_src    = w_alu_src;
    w_id_ex.result_src = w_result_src;
    w_id_ex.alu_ctrl   = w_alu_ctrl;
    w_id_ex.illegal    = w_illegal;
    w_id_ex.rd1        = w_rd1;
    w_id_ex.rd2        = w_rd2;
    w_id_ex.imm        = w_imm;
    w_id_ex.pc         = PCD;
    w_id_ex.pc_plus4   = PCPlus4D;
    w_id_ex.rs1        = Rs1D;
    w_id_ex.rs2        = Rs2D;
    w_id_ex.rd         = instrD[11:7];
  end

  // ID/EX pipeline register; reset outranks flush, flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id_ex <= '0;
    end else if (FlushE) begin
      r_id_ex <= '0;
    end else begin
      r_id_ex <= w_id_ex;
    end
  end

  assign RegWriteE   = r_id_ex.reg_write;
  assign MemWriteE   = r_id_ex.mem_write;
  assign JumpE       = r_id_ex.jump;
  assign BranchE     = r_id_ex.branch;
  assign ALUSrcE     = r_id_ex.alu_src;
  assign ResultSrcE  = r_id_ex.result_src;
  assign ALUControlE = r_id_ex.alu_ctrl;
  assign IllegalE    = r_id_ex.illegal;
  assign RD1E        = r_id_ex.rd1;
  assign RD2E        = r_id_ex.rd2;
  assign ImmExtE     = r_id_ex.imm;
  assign PCE         = r_id_ex.pc;
  assign PCPlus4E    = r_id_ex.pc_plus4;
  assign Rs1E        = r_id_ex.rs1;
  assign Rs2E        = r_id_ex.rs2;
  assign RdE         = r_id_ex.rd;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decode
//  Description : Directed self-checking bench for instruction_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        IllegalE;

  int checks;
  int failures;

  instruction_decode #(.WORD_WIDTH(32), .NUM_REGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instrD      (instrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .FlushE      (FlushE),
    .RegWriteW   (RegWriteW),
    .RdW         (RdW),
    .ResultW     (ResultW),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ResultSrcE  (ResultSrcE),
    .ALUControlE (ALUControlE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .IllegalE    (IllegalE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    instrD    = 32'h004181B3;
    PCD       = 32'h0000_0040;
    PCPlus4D  = 32'h0000_0044;
    FlushE    = 1'b0;
    RegWriteW = 1'b1;
    RdW       = 5'd5;
    ResultW   = 32'h0000_00AA;

    // Reset edge: all E outputs zero.
    tick();
    chk("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
    chk("rst_rdE",      {27'd0, RdE}, 32'd0);
    chk("rst_pcE",      PCE, 32'd0);
    chk("rst_pcp4E",    PCPlus4E, 32'd0);
    chk("rst_illegal",  {31'd0, IllegalE}, 32'd0);

    // Write x5 = 0xAA, then confirm it is readable.
    reset  = 1'b1;
    instrD = 32'h00000033;
    tick();
    RegWriteW = 1'b0;
    instrD    = 32'h00028333;           // add x6,x5,x0
    tick();
    chk("x5_written", RD1E, 32'h0000_00AA);

    // Reset after writes clears x5.
    reset = 1'b0;
    tick();
    chk("rst2_rd1E",  RD1E, 32'd0);
    chk("rst2_rdE",   {27'd0, RdE}, 32'd0);
    reset = 1'b1;
    tick();
    chk("x5_cleared", RD1E, 32'd0);
    chk("add6_rdE",   {27'd0, RdE}, 32'd6);
    chk("add6_rw",    {31'd0, RegWriteE}, 32'd1);

    // x3 = 7, x4 = 5, then add x3,x3,x4.
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'd7; instrD = 32'h00000033;
    tick();
    RdW = 5'd4; ResultW = 32'd5;
    tick();
    RegWriteW = 1'b0;
    instrD    = 32'h004181B3;
    PCD       = 32'h0000_0080;
    PCPlus4D  = 32'h0000_0084;
    tick();
    chk("add_rd1",    RD1E, 32'd7);
    chk("add_rd2",    RD2E, 32'd5);
    chk("add_alu",    {29'd0, ALUControlE}, 32'd0);
    chk("add_rw",     {31'd0, RegWriteE}, 32'd1);
    chk("add_rdE",    {27'd0, RdE}, 32'd3);
    chk("add_alusrc", {31'd0, ALUSrcE}, 32'd0);
    chk("add_imm",    ImmExtE, 32'd0);
    chk("add_rs1E",   {27'd0, Rs1E}, 32'd3);
    chk("add_rs2E",   {27'd0, Rs2E}, 32'd4);
    chk("add_pcE",    PCE, 32'h0000_0080);

    // lw x1,-4(x2) with simultaneous writeback of x2 (write-through).
    instrD = 32'hFFC12083;
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h0000_1234;
    tick();
    chk("lw_rd1_wt",  RD1E, 32'h0000_1234);
    chk("lw_imm",     ImmExtE, 32'hFFFF_FFFC);
    chk("lw_ressrc",  {30'd0, ResultSrcE}, 32'd1);
    chk("lw_alusrc",  {31'd0, ALUSrcE}, 32'd1);
    chk("lw_rw",      {31'd0, RegWriteE}, 32'd1);
    chk("lw_mw",      {31'd0, MemWriteE}, 32'd0);
    chk("lw_rdE",     {27'd0, RdE}, 32'd1);

    // Write to x0 is discarded: add x0,x0,x0 while writing x0 = 0xFF.
    instrD = 32'h00000033;
    RdW = 5'd0; ResultW = 32'h0000_00FF;
    tick();
    chk("x0_wt",      RD1E, 32'd0);
    RegWriteW = 1'b0;
    tick();
    chk("x0_stored",  RD1E, 32'd0);

    // beq x1,x2,-4 flushed, while x1 = 0x55 is written back.
    instrD = 32'hFE208EE3;
    PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
    FlushE = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h0000_0055;
    tick();
    chk("fl_branch",  {31'd0, BranchE}, 32'd0);
    chk("fl_imm",     ImmExtE, 32'd0);
    chk("fl_rd2",     RD2E, 32'd0);
    chk("fl_pcE",     PCE, 32'd0);
    chk("fl_alu",     {29'd0, ALUControlE}, 32'd0);
    chk("fl_rs1E",    {27'd0, Rs1E}, 32'd0);
    FlushE = 1'b0;
    RegWriteW = 1'b0;
    tick();
    chk("beq_branch", {31'd0, BranchE}, 32'd1);
    chk("beq_alu",    {29'd0, ALUControlE}, 32'd1);
    chk("beq_imm",    ImmExtE, 32'hFFFF_FFFC);
    chk("beq_rw",     {31'd0, RegWriteE}, 32'd0);
    chk("beq_rd1",    RD1E, 32'h0000_0055);
    chk("beq_rd2",    RD2E, 32'h0000_1234);
    chk("beq_pcE",    PCE, 32'h0000_0100);
    chk("beq_pcp4E",  PCPlus4E, 32'h0000_0104);
    chk("beq_rdE",    {27'd0, RdE}, 32'd29);

    // sw x2,8(x1).
    instrD = 32'h0020A423;
    tick();
    chk("sw_mw",      {31'd0, MemWriteE}, 32'd1);
    chk("sw_imm",     ImmExtE, 32'd8);
    chk("sw_rw",      {31'd0, RegWriteE}, 32'd0);
    chk("sw_rdE",     {27'd0, RdE}, 32'd8);
    chk("sw_alusrc",  {31'd0, ALUSrcE}, 32'd1);

    // jal x1,-12.
    instrD = 32'hFF5FF0EF;
    tick();
    chk("jal_jump",   {31'd0, JumpE}, 32'd1);
    chk("jal_imm",    ImmExtE, 32'hFFFF_FFF4);
    chk("jal_ressrc", {30'd0, ResultSrcE}, 32'd2);
    chk("jal_rw",     {31'd0, RegWriteE}, 32'd1);

    // sub x5,x3,x4.
    instrD = 32'h404182B3;
    tick();
    chk("sub_alu",    {29'd0, ALUControlE}, 32'd1);

    // addi x5,x3,-1024 (imm bit 30 set must not select sub).
    instrD = 32'hC0018293;
    tick();
    chk("addi_alu",   {29'd0, ALUControlE}, 32'd0);
    chk("addi_imm",   ImmExtE, 32'hFFFF_FC00);
    chk("addi_alusrc",{31'd0, ALUSrcE}, 32'd1);

    // andi x5,x3,15.
    instrD = 32'h00F1F293;
    tick();
    chk("andi_alu",   {29'd0, ALUControlE}, 32'd2);
    chk("andi_imm",   ImmExtE, 32'd15);

    // or / slt / xor R-type.
    instrD = 32'h0041E333;
    tick();
    chk("or_alu",     {29'd0, ALUControlE}, 32'd3);
    instrD = 32'h0041A333;
    tick();
    chk("slt_alu",    {29'd0, ALUControlE}, 32'd5);
    instrD = 32'h0041C333;
    tick();
    chk("xor_alu",    {29'd0, ALUControlE}, 32'd4);

    // sll x6,x3,x4: unsupported funct3.
    instrD = 32'h00419333;
    tick();
    chk("sll_illegal",{31'd0, IllegalE}, 32'd1);
    chk("sll_rw",     {31'd0, RegWriteE}, 32'd0);

    // All-zero instruction is illegal.
    instrD = 32'h00000000;
    tick();
    chk("zero_illegal",{31'd0, IllegalE}, 32'd1);
    chk("zero_rw",     {31'd0, RegWriteE}, 32'd0);
    chk("zero_mw",     {31'd0, MemWriteE}, 32'd0);
    chk("zero_imm",    ImmExtE, 32'd0);

    // Flush clears a pending illegal flag.
    FlushE = 1'b1;
    tick();
    chk("fl_illegal",  {31'd0, IllegalE}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
